// File: rtl/output_layer_mac.sv
// Purpose : final fully-connected layer; buffers N_IN unsigned activations, then computes N_CLASS signed dot products against an external synchronous weight ROM, applying ReLU, >>>SHIFT and 12-bit unsigned saturation.
// Latency : first ROM read one cycle after the last activation is accepted; the class-c score pulses N_IN*(c+1)+1 cycles after that first read.
// Backpr. : feat_ready is high only in LOAD; upstream must hold feat_valid/feat_data through MAC. Score output has no backpressure.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   feat_valid/feat_data/feat_ready activation input handshake
//   w_rd_en/w_addr/w_data           weight ROM port (data valid 1 cycle after w_rd_en)
//   score_valid/score_data/score_sat single-cycle class score strobe
//   frame_done                      coincides with the last score of a frame
module output_layer_mac #(
    parameter int N_IN    = 16,
    parameter int N_CLASS = 10,
    parameter int IN_W    = 8,
    parameter int W_W     = 8,
    parameter int ACC_W   = 24,
    parameter int SHIFT   = 4,
    localparam int AW     = $clog2(N_IN * N_CLASS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            feat_valid,
    input  logic [IN_W-1:0] feat_data,
    output logic            feat_ready,
    output logic            w_rd_en,
    output logic [AW-1:0]   w_addr,
    input  logic [W_W-1:0]  w_data,
    output logic            score_valid,
    output logic [11:0]     score_data,
    output logic            score_sat,
    output logic            frame_done
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
    localparam int PW = IN_W + W_W + 1;

    localparam logic [IW-1:0]          I_LAST    = IW'(N_IN - 1);
    localparam logic [CW-1:0]          C_LAST    = CW'(N_CLASS - 1);
    localparam logic signed [ACC_W-1:0] ACC_ZERO  = '0;
    localparam logic signed [ACC_W-1:0] SCORE_MAX = ACC_W'(4095);

    typedef enum logic {
        LOAD = 1'b0,
        MAC  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [IN_W-1:0] buffer [N_IN];

    logic [IW-1:0] fcnt;
    logic [IW-1:0] i_cnt, i_d;
    logic [CW-1:0] c_cnt, c_d;
    logic [AW-1:0] addr;
    logic          issue_done;   // all N_IN*N_CLASS reads issued, last product still in flight
    logic          rd_d;         // w_data is valid this cycle

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;

    logic accept;
    logic last_acc;

    assign accept   = feat_valid && feat_ready;
    assign last_acc = rd_d && (i_d == I_LAST) && (c_d == C_LAST);
    assign w_addr   = addr;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        feat_ready = 1'b0;
        w_rd_en    = 1'b0;
        case (state)
            LOAD: begin
                feat_ready = 1'b1;
                if (feat_valid && (fcnt == I_LAST)) begin
                    state_nxt = MAC;
                end
            end
            MAC: begin
                w_rd_en = !issue_done;
                if (last_acc) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // ---------------- activation buffer (not reset) ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[fcnt] <= feat_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= '0;
        end else if (accept) begin
            fcnt <= (fcnt == I_LAST) ? '0 : fcnt + 1'b1;
        end
    end

    // ---------------- read issue: class/index counters plus a running address ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt      <= '0;
            c_cnt      <= '0;
            addr       <= '0;
            issue_done <= 1'b0;
            rd_d       <= 1'b0;
            i_d        <= '0;
            c_d        <= '0;
        end else begin
            rd_d <= w_rd_en;
            i_d  <= i_cnt;
            c_d  <= c_cnt;
            if (w_rd_en) begin
                if (i_cnt == I_LAST) begin
                    i_cnt <= '0;
                    if (c_cnt == C_LAST) begin
                        c_cnt      <= '0;
                        addr       <= '0;
                        issue_done <= 1'b1;
                    end else begin
                        c_cnt <= c_cnt + 1'b1;
                        addr  <= addr + 1'b1;
                    end
                end else begin
                    i_cnt <= i_cnt + 1'b1;
                    addr  <= addr + 1'b1;
                end
            end
            if (last_acc) begin
                issue_done <= 1'b0;
            end
        end
    end

    // ---------------- multiply-accumulate ----------------
    // Activation is zero-extended to make it a non-negative signed operand.
    assign prod     = $signed({1'b0, buffer[i_d]}) * $signed(w_data);
    assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
    // Index 0 of each class restarts the sum, so no separate clear cycle is needed.
    assign acc_base = (i_d == '0) ? ACC_ZERO : acc;
    assign sum      = acc_base + prod_ext;
    assign shifted  = sum >>> SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            score_valid <= 1'b0;
            score_data  <= '0;
            score_sat   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            score_valid <= 1'b0;
            frame_done  <= 1'b0;
            if (rd_d) begin
                acc <= sum;
                if (i_d == I_LAST) begin
                    score_valid <= 1'b1;
                    frame_done  <= (c_d == C_LAST);
                    if (sum[ACC_W-1]) begin
                        score_data <= '0;
                        score_sat  <= 1'b0;
                    end else if (shifted > SCORE_MAX) begin
                        score_data <= 12'd4095;
                        score_sat  <= 1'b1;
                    end else begin
                        score_data <= shifted[11:0];
                        score_sat  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_output_layer_mac.sv
// Purpose : directed scoreboard bench for output_layer_mac with a synchronous weight ROM model.
// Latency : expected scores carry their cycle offset from the first ROM read of the frame.
// Backpr. : driver holds feat_valid/feat_data until feat_ready is seen at the edge.
module tb_output_layer_mac;

    localparam int N_IN    = 16;
    localparam int N_CLASS = 10;

    logic        clk;
    logic        rst_n;
    logic        feat_valid;
    logic [7:0]  feat_data;
    logic        feat_ready;
    logic        w_rd_en;
    logic [7:0]  w_addr;
    logic [7:0]  w_data;
    logic        score_valid;
    logic [11:0] score_data;
    logic        score_sat;
    logic        frame_done;

    output_layer_mac dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .feat_valid (feat_valid),
        .feat_data  (feat_data),
        .feat_ready (feat_ready),
        .w_rd_en    (w_rd_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .score_valid(score_valid),
        .score_data (score_data),
        .score_sat  (score_sat),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous weight ROM: data appears one cycle after the read strobe.
    logic signed [7:0] rom [N_IN*N_CLASS];
    initial w_data = '0;
    always @(posedge clk) begin
        if (w_rd_en) w_data <= rom[w_addr];
    end

    typedef struct {
        logic [11:0] d;
        logic        s;
        logic        f;
        int          t;
    } exp_t;

    exp_t q[$];
    logic [7:0] act [N_IN];

    int n_cmp  = 0;
    int n_fail = 0;
    int t_cnt  = 0;
    int n_accept = 0, n_reentry = 0;
    int addr_err = 0, ready_err = 0, consec_err = 0, fd_err = 0;
    logic prev_rd = 1'b0, prev_sv = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_rd = 1'b0;
            prev_sv = 1'b0;
        end else begin
            if (w_rd_en && !prev_rd) t_cnt = 0;
            else                     t_cnt++;
            if (w_rd_en && (int'(w_addr) != t_cnt)) addr_err++;
            if (w_rd_en && feat_ready) ready_err++;
            if (feat_valid && feat_ready) begin
                n_accept++;
                if (frame_done) n_reentry++;
            end
            if (score_valid && prev_sv) consec_err++;
            if (frame_done && !score_valid) fd_err++;
            if (score_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_score: got score_data=%0d at t=%0d, expected no score", score_data, t_cnt);
                end else begin
                    e = q.pop_front();
                    chk("score_data", int'(score_data), int'(e.d));
                    chk("score_sat",  int'(score_sat),  int'(e.s));
                    chk("frame_done", int'(frame_done), int'(e.f));
                    chk("score_cycle", t_cnt, e.t);
                end
            end
            prev_rd = w_rd_en;
            prev_sv = score_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_exp(input int c, input int d, input logic s);
        exp_t e;
        e.d = 12'(d);
        e.s = s;
        e.f = (c == N_CLASS - 1);
        e.t = (c + 1) * N_IN + 1;
        q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the edge of the last accept.
    task automatic send_frame(input logic hold);
        int k = 0;
        int guard = 0;
        logic took;
        while (k < N_IN && guard < 1000) begin
            feat_valid = 1'b1;
            feat_data  = act[k];
            @(negedge clk);
            took = feat_ready;
            @(posedge clk);
            #1;
            if (took) k++;
            guard++;
        end
        if (k != N_IN) chk("send_frame_accepts", k, N_IN);
        if (!hold) feat_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 400 && q.size() != 0; k++) @(posedge clk);
        chk(name, q.size(), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int a0, r0;
        rst_n      = 1'b0;
        feat_valid = 1'b0;
        feat_data  = '0;
        for (int a = 0; a < N_IN*N_CLASS; a++) rom[a] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_feat_ready",  int'(feat_ready),  1);
        chk("rst_w_rd_en",     int'(w_rd_en),     0);
        chk("rst_w_addr",      int'(w_addr),      0);
        chk("rst_score_valid", int'(score_valid), 0);
        chk("rst_score_data",  int'(score_data),  0);
        chk("rst_score_sat",   int'(score_sat),   0);
        chk("rst_frame_done",  int'(frame_done),  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-zero activations, arbitrary weights -> all scores 0.
        for (int i = 0; i < N_IN; i++) act[i] = 8'd0;
        for (int a = 0; a < N_IN*N_CLASS; a++) rom[a] = 8'(a * 13 - 77);
        for (int c = 0; c < N_CLASS; c++) push_exp(c, 0, 1'b0);
        a0 = n_accept;
        send_frame(1'b0);
        wait_done("zeros_complete");
        chk("zeros_accepts", n_accept - a0, N_IN);

        // Activations 1, weight c+1 -> score c+1.
        for (int i = 0; i < N_IN; i++) act[i] = 8'd1;
        for (int c = 0; c < N_CLASS; c++)
            for (int i = 0; i < N_IN; i++) rom[c*N_IN+i] = 8'(c + 1);
        for (int c = 0; c < N_CLASS; c++) push_exp(c, c + 1, 1'b0);
        send_frame(1'b0);
        wait_done("ramp_complete");

        // 255 x 127 -> 32385 after shift -> saturated.
        for (int i = 0; i < N_IN; i++) act[i] = 8'd255;
        for (int a = 0; a < N_IN*N_CLASS; a++) rom[a] = 8'sd127;
        for (int c = 0; c < N_CLASS; c++) push_exp(c, 4095, 1'b1);
        send_frame(1'b0);
        wait_done("sat_complete");

        // 255 x -128 -> negative -> ReLU to 0.
        for (int a = 0; a < N_IN*N_CLASS; a++) rom[a] = -8'sd128;
        for (int c = 0; c < N_CLASS; c++) push_exp(c, 0, 1'b0);
        send_frame(1'b0);
        wait_done("neg_complete");

        // Activations i, one-hot weight 16 at i==c -> score c.
        for (int i = 0; i < N_IN; i++) act[i] = 8'(i);
        for (int c = 0; c < N_CLASS; c++)
            for (int i = 0; i < N_IN; i++) rom[c*N_IN+i] = (i == c) ? 8'sd16 : 8'sd0;
        for (int c = 0; c < N_CLASS; c++) push_exp(c, c, 1'b0);
        send_frame(1'b0);
        wait_done("onehot_complete");

        // Activations 100, weight 10c-40 -> 100*(10c-40): 0 for c<=4, then 1000..4000, 5000 saturates.
        for (int i = 0; i < N_IN; i++) act[i] = 8'd100;
        for (int c = 0; c < N_CLASS; c++)
            for (int i = 0; i < N_IN; i++) rom[c*N_IN+i] = 8'(c * 10 - 40);
        push_exp(0, 0, 1'b0);    push_exp(1, 0, 1'b0);    push_exp(2, 0, 1'b0);
        push_exp(3, 0, 1'b0);    push_exp(4, 0, 1'b0);    push_exp(5, 1000, 1'b0);
        push_exp(6, 2000, 1'b0); push_exp(7, 3000, 1'b0); push_exp(8, 4000, 1'b0);
        push_exp(9, 4095, 1'b1);
        send_frame(1'b0);
        wait_done("mixed_complete");

        // Reset in MAC after class 3 scored: nothing more comes out, then a clean frame.
        for (int i = 0; i < N_IN; i++) act[i] = 8'd1;
        for (int c = 0; c < N_CLASS; c++)
            for (int i = 0; i < N_IN; i++) rom[c*N_IN+i] = 8'(c + 1);
        for (int c = 0; c < N_CLASS; c++) push_exp(c, c + 1, 1'b0);
        send_frame(1'b0);
        for (int k = 0; k < 300 && q.size() > 6; k++) @(posedge clk);
        chk("midreset_classes_before", N_CLASS - q.size(), 4);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_w_rd_en", int'(w_rd_en), 0);
        chk("midreset_score_valid", int'(score_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", int'(feat_ready), 1);
        repeat (200) @(posedge clk);
        #1;
        for (int c = 0; c < N_CLASS; c++) push_exp(c, c + 1, 1'b0);
        send_frame(1'b0);
        wait_done("post_reset_complete");

        // feat_valid held high over two back-to-back frames.
        for (int c = 0; c < N_CLASS; c++)
            for (int i = 0; i < N_IN; i++) rom[c*N_IN+i] = (i == c) ? 8'sd16 : 8'sd0;
        for (int i = 0; i < N_IN; i++) act[i] = 8'(i);
        for (int c = 0; c < N_CLASS; c++) push_exp(c, c, 1'b0);
        for (int c = 0; c < N_CLASS; c++) push_exp(c, 15 - c, 1'b0);
        a0 = n_accept;
        r0 = n_reentry;
        send_frame(1'b1);
        for (int i = 0; i < N_IN; i++) act[i] = 8'(15 - i);
        send_frame(1'b0);
        wait_done("hold_complete");
        chk("hold_accepts", n_accept - a0, 2 * N_IN);
        chk("hold_reentry_accept", n_reentry - r0, 1);

        chk("addr_sweep_errors", addr_err, 0);
        chk("ready_in_mac_errors", ready_err, 0);
        chk("consecutive_score_errors", consec_err, 0);
        chk("lone_frame_done_errors", fd_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
